system_0_sysid_checker: RTL and testbench
=========================================

# system_0_sysid_checker

Avalon-MM read initiator that checks the system ID peripheral after reset or on demand. It sits on the control bus as a master and performs two single-word reads: ID at word 0, then timestamp at word 1. It compares both against build-time constants and reports pass/fail, the captured values and a per-transaction timeout. Software or the boot sequencer uses it to refuse operation on a mismatched FPGA image.

## Interface
Parameters:
- EXPECTED_ID, 32'd0: value required at word address 0.
- EXPECTED_TIMESTAMP, 32'd1765368152: value required at word address 1.
- TIMEOUT_CYCLES, 255: maximum cycles from read issue to readdatavalid; legal range 1..65535.

Ports:
- clock  in  1  single clock.
- reset_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE or DONE.
- address  out  1  Avalon word address (0 = ID, 1 = timestamp).
- read  out  1  Avalon read request.
- waitrequest  in  1  slave stall; read and address are held while high.
- readdata  in  32  slave read data.
- readdatavalid  in  1  qualifies readdata; minimum latency 1 cycle after acceptance.
- busy  out  1  high from the cycle after start until entry to DONE.
- done  out  1  level; high in DONE until the next start or reset.
- pass  out  1  id_ok & ts_ok & ~timeout; valid while done.
- id_ok, ts_ok  out  1 each  per-word compare result.
- timeout  out  1  a transaction exceeded TIMEOUT_CYCLES.
- id_value, ts_value  out  32 each  captured readdata.
- retry_count  out  2  retries consumed (see Configuration).

## Operation
- Reset value of all outputs: 0. FSM state after reset: IDLE.
- States and transitions:
  - IDLE: on start, go to RD_ID.
  - RD_ID: address=0, read=1. When waitrequest=0, go to WAIT_ID.
  - WAIT_ID: on readdatavalid, capture id_value and id_ok, then go to RD_TS.
  - RD_TS: address=1, read=1. When waitrequest=0, go to WAIT_TS.
  - WAIT_TS: on readdatavalid, capture ts_value and ts_ok, then go to DONE.
  - DONE: on start, clear all result outputs and go to RD_ID.
- On leaving IDLE/DONE via start, id_ok, ts_ok, timeout, pass, id_value and ts_value are cleared.
- The timeout counter is 16 bits. It is cleared on entry to RD_ID/RD_TS and increments in every RD/WAIT cycle. When the count equals TIMEOUT_CYCLES without readdatavalid:
  - timeout=1;
  - read drops the next cycle;
  - the FSM goes to DONE with pass=0.
- readdatavalid is ignored in IDLE, RD_x and DONE. Late responses to an abandoned read are discarded.
- start while busy is ignored.
- Compare is full 32-bit equality; no masking.

## Timing
- With waitrequest=0 and 1-cycle read latency, start is sampled at edge 0:
  - read high for word 0 in cycle 1; readdatavalid in cycle 2;
  - read high for word 1 in cycle 3; readdatavalid in cycle 4;
  - done=1 from cycle 5. Total latency: 5 cycles.
- Each waitrequest cycle adds one cycle. Each extra read-latency cycle adds one cycle.
- read, address and all result outputs are registered; there is no combinational input-to-output path.
- Reset mid-operation (reset_n=0 sampled at an edge): read=0 and all outputs are 0 after that edge, and the FSM is in IDLE. Any in-flight response is ignored.
- Simultaneous timeout expiry and readdatavalid in the same cycle: the data wins. It is captured, and timeout stays 0.

## Configuration
- SYSID_CHECKER_RETRY_EN defined:
  - On a compare failure or timeout at the end of WAIT_TS (or at timeout), if retry_count < 3, retry_count increments and the FSM returns to RD_ID instead of DONE.
  - Results are cleared on each retry.
  - done asserts only on pass or after the third retry fails.
  - retry_count is cleared on start.
- Not defined: no retries; the first failure goes to DONE; retry_count is tied to 0.

## Test plan
- Nominal: slave returns 0 at word 0 and 1765368152 at word 1, no waitrequest, latency 1 -> done in cycle 5, pass=1, id_ok=ts_ok=1, ts_value=1765368152.
- Stall: waitrequest held 3 cycles on each read -> address/read stable while stalled, done in cycle 11, pass=1.
- Mismatch: word 1 returns 32'h0 -> ts_ok=0, id_ok=1, pass=0. With RETRY_EN, retry_count=3 and 4 read pairs are observed before done.
- Timeout: TIMEOUT_CYCLES=4, readdatavalid never asserted -> read drops after 4 cycles, timeout=1, pass=0, done=1. A late readdatavalid 10 cycles later leaves results unchanged.
- Reset mid-read: reset_n=0 for one edge during WAIT_TS -> all outputs 0 on the following cycle. A subsequent start completes with pass=1.
- Boundary: readdatavalid coincident with timeout expiry -> data captured, timeout=0; start pulsed while busy is ignored.

Source files
------------

// File: rtl/system_0_sysid_checker.sv
// Avalon-MM read initiator that checks the system ID peripheral (ID at word 0, timestamp at word 1).
// Optional retry on failure: define SYSID_CHECKER_RETRY_EN.
`timescale 1ns/1ps
module system_0_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1765368152,
   parameter int unsigned TIMEOUT_CYCLES     = 255
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        address,
   output logic        read,
   input  logic        waitrequest,
   input  logic [31:0] readdata,
   input  logic        readdatavalid,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic [1:0]  retry_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ID,
      S_WAIT_ID,
      S_RD_TS,
      S_WAIT_TS,
      S_DONE
   } state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic        read_q, read_d;
   logic        address_q, address_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic        id_ok_q, id_ok_d;
   logic        ts_ok_q, ts_ok_d;
   logic        timeout_q, timeout_d;
   logic [31:0] id_value_q, id_value_d;
   logic [31:0] ts_value_q, ts_value_d;
   logic [1:0]  retry_q, retry_d;

   logic in_rd, in_wait, rdv_take, expired, abort, start_take;
   logic ts_match, ts_fail, can_retry, retry_now;

   assign in_rd      = (state_q == S_RD_ID) || (state_q == S_RD_TS);
   assign in_wait    = (state_q == S_WAIT_ID) || (state_q == S_WAIT_TS);
   assign rdv_take   = in_wait && readdatavalid;
   assign expired    = (in_rd || in_wait) && (tmo_cnt_q == TO_LAST);
   // Data arriving in the expiry cycle wins over the timeout.
   assign abort      = expired && !rdv_take;
   assign start_take = start && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign ts_match   = (readdata == EXPECTED_TIMESTAMP);
   assign ts_fail    = !(id_ok_q && ts_match);

`ifdef SYSID_CHECKER_RETRY_EN
   assign can_retry = (retry_q != 2'd3);
`else
   assign can_retry = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         tmo_cnt_q  <= '0;
         read_q     <= 1'b0;
         address_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         id_ok_q    <= 1'b0;
         ts_ok_q    <= 1'b0;
         timeout_q  <= 1'b0;
         id_value_q <= '0;
         ts_value_q <= '0;
         retry_q    <= '0;
      end else begin
         state_q    <= state_d;
         tmo_cnt_q  <= tmo_cnt_d;
         read_q     <= read_d;
         address_q  <= address_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         id_ok_q    <= id_ok_d;
         ts_ok_q    <= ts_ok_d;
         timeout_q  <= timeout_d;
         id_value_q <= id_value_d;
         ts_value_q <= ts_value_d;
         retry_q    <= retry_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      retry_now = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) state_d = S_RD_ID;
         end
         S_RD_ID, S_RD_TS: begin
            if (abort) begin
               if (can_retry) begin
                  state_d   = S_RD_ID;
                  retry_now = 1'b1;
               end else begin
                  state_d = S_DONE;
               end
            end else if (!waitrequest) begin
               state_d = (state_q == S_RD_ID) ? S_WAIT_ID : S_WAIT_TS;
            end
         end
         S_WAIT_ID: begin
            if (rdv_take) begin
               state_d = S_RD_TS;
            end else if (abort) begin
               if (can_retry) begin
                  state_d   = S_RD_ID;
                  retry_now = 1'b1;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_WAIT_TS: begin
            if (rdv_take || abort) begin
               if (can_retry && (abort || ts_fail)) begin
                  state_d   = S_RD_ID;
                  retry_now = 1'b1;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      read_d     = (state_d == S_RD_ID) || (state_d == S_RD_TS);
      address_d  = (state_d == S_RD_TS);
      busy_d     = !((state_d == S_IDLE) || (state_d == S_DONE));
      done_d     = (state_d == S_DONE);
      pass_d     = pass_q;
      id_ok_d    = id_ok_q;
      ts_ok_d    = ts_ok_q;
      timeout_d  = timeout_q;
      id_value_d = id_value_q;
      ts_value_d = ts_value_q;
      retry_d    = retry_q;
      tmo_cnt_d  = tmo_cnt_q;

      // Counter restarts on every fresh read, including a retry back into RD_ID.
      if ((state_d == S_RD_ID || state_d == S_RD_TS) && (state_d != state_q || retry_now)) begin
         tmo_cnt_d = '0;
      end else if (in_rd || in_wait) begin
         tmo_cnt_d = tmo_cnt_q + 16'd1;
      end

      if (rdv_take && state_q == S_WAIT_ID) begin
         id_value_d = readdata;
         id_ok_d    = (readdata == EXPECTED_ID);
      end
      if (rdv_take && state_q == S_WAIT_TS) begin
         ts_value_d = readdata;
         ts_ok_d    = ts_match;
         pass_d     = id_ok_q && ts_match;
      end
      if (abort) begin
         timeout_d = 1'b1;
         pass_d    = 1'b0;
      end

      if (start_take || retry_now) begin
         pass_d     = 1'b0;
         id_ok_d    = 1'b0;
         ts_ok_d    = 1'b0;
         timeout_d  = 1'b0;
         id_value_d = '0;
         ts_value_d = '0;
      end

`ifdef SYSID_CHECKER_RETRY_EN
      if (start_take) begin
         retry_d = '0;
      end else if (retry_now) begin
         retry_d = retry_q + 2'd1;
      end
`else
      retry_d = '0;
`endif
   end

   assign address     = address_q;
   assign read        = read_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign id_ok       = id_ok_q;
   assign ts_ok       = ts_ok_q;
   assign timeout     = timeout_q;
   assign id_value    = id_value_q;
   assign ts_value    = ts_value_q;
   assign retry_count = retry_q;

endmodule

// File: tb/tb_system_0_sysid_checker.sv
// Scoreboard bench for system_0_sysid_checker with a reactive Avalon slave model (default build).
`timescale 1ns/1ps
module tb_system_0_sysid_checker;

   localparam int          TO     = 6;
   localparam logic [31:0] EXP_ID = 32'd0;
   localparam logic [31:0] EXP_TS = 32'd1765368152;

   logic        clock = 1'b0;
   logic        reset_n, start;
   logic        address, read, waitrequest, readdatavalid;
   logic [31:0] readdata;
   logic        busy, done, pass, id_ok, ts_ok, timeout;
   logic [31:0] id_value, ts_value;
   logic [1:0]  retry_count;

   always #5 clock = ~clock;

   system_0_sysid_checker #(
      .EXPECTED_ID        (EXP_ID),
      .EXPECTED_TIMESTAMP (EXP_TS),
      .TIMEOUT_CYCLES     (TO)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .start         (start),
      .address       (address),
      .read          (read),
      .waitrequest   (waitrequest),
      .readdata      (readdata),
      .readdatavalid (readdatavalid),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .id_ok         (id_ok),
      .ts_ok         (ts_ok),
      .timeout       (timeout),
      .id_value      (id_value),
      .ts_value      (ts_value),
      .retry_count   (retry_count)
   );

   typedef struct {
      int          lat;
      int          rdc;
      logic        pass;
      logic        id_ok;
      logic        ts_ok;
      logic        tmo;
      logic [31:0] idv;
      logic [31:0] tsv;
   } exp_t;

   exp_t sb[$];
   exp_t last_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Slave model: cfg_stall waitrequest cycles per read, response cfg_lat cycles after acceptance (0 = never).
   int          cfg_stall = 0;
   int          cfg_lat   = 1;
   logic [31:0] cfg_d0    = '0;
   logic [31:0] cfg_d1    = '0;
   int          stall_left = 0;
   int          pend_cnt   = 0;
   bit          in_req     = 1'b0;
   logic [31:0] pend_data  = '0;

   initial begin
      waitrequest   = 1'b0;
      readdatavalid = 1'b0;
      readdata      = '0;
      forever begin
         @(posedge clock);
         #1;
         readdatavalid = 1'b0;
         if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               readdatavalid = 1'b1;
               readdata      = pend_data;
            end
         end
         if (!read) begin
            in_req = 1'b0;
         end else if (!in_req) begin
            in_req     = 1'b1;
            stall_left = cfg_stall;
         end
         waitrequest = 1'b0;
         if (in_req) begin
            if (stall_left > 0) begin
               waitrequest = 1'b1;
               stall_left--;
            end else begin
               in_req = 1'b0;
               if (cfg_lat > 0) begin
                  pend_cnt  = cfg_lat;
                  pend_data = address ? cfg_d1 : cfg_d0;
               end
            end
         end
      end
   end

   // Bus monitor: read-high cycles and address/read hold violations while stalled.
   int   rd_cycles  = 0;
   int   hold_err   = 0;
   logic prev_stall = 1'b0;
   logic prev_addr  = 1'b0;

   always @(negedge clock) begin
      if (read) rd_cycles++;
      if (prev_stall && !timeout && (!read || address != prev_addr)) hold_err++;
      prev_stall = read && waitrequest;
      prev_addr  = address;
   end

   function automatic exp_t model(input int stall, input int lat, input logic [31:0] d0, input logic [31:0] d1);
      exp_t e;
      int   cyc;
      int   t;
      e.lat = 0; e.rdc = 0; e.pass = 1'b0; e.id_ok = 1'b0; e.ts_ok = 1'b0;
      e.tmo = 1'b0; e.idv = '0; e.tsv = '0;
      cyc = 0;
      for (int w = 0; w < 2; w++) begin
         t = stall + 1 + lat;
         if (lat == 0 || t > TO) begin
            e.tmo = 1'b1;
            e.rdc += (stall + 1 < TO) ? stall + 1 : TO;
            cyc   += TO;
            break;
         end
         e.rdc += stall + 1;
         cyc   += t;
         if (w == 0) begin
            e.idv   = d0;
            e.id_ok = (d0 == EXP_ID);
         end else begin
            e.tsv   = d1;
            e.ts_ok = (d1 == EXP_TS);
         end
      end
      e.pass = e.id_ok && e.ts_ok && !e.tmo;
      e.lat  = cyc + 1;
      return e;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic run(input int stall, input int lat, input logic [31:0] d0, input logic [31:0] d1,
                      input bit poke_busy);
      exp_t e;
      bit   seen;
      int   got_lat;
      int   rc0, he0;
      cfg_stall = stall;
      cfg_lat   = lat;
      cfg_d0    = d0;
      cfg_d1    = d1;
      sb.push_back(model(stall, lat, d0, d1));
      rc0     = rd_cycles;
      he0     = hold_err;
      seen    = 1'b0;
      got_lat = 0;
      start   = 1'b1;
      for (int n = 1; n <= 200 && !seen; n++) begin
         @(posedge clock);
         #1;
         if (n == 1) begin
            start = 1'b0;
            check("busy_first", 32'(busy), 32'd1);
         end
         if (poke_busy && n == 2) start = 1'b1;
         if (poke_busy && n == 3) start = 1'b0;
         if (done) begin
            seen    = 1'b1;
            got_lat = n;
         end
      end
      check("done_seen", 32'(seen), 32'd1);
      e      = sb.pop_front();
      last_e = e;
      if (seen) begin
         check("latency",   32'(got_lat),            32'(e.lat));
         check("pass",      32'(pass),               32'(e.pass));
         check("id_ok",     32'(id_ok),              32'(e.id_ok));
         check("ts_ok",     32'(ts_ok),              32'(e.ts_ok));
         check("timeout",   32'(timeout),            32'(e.tmo));
         check("id_value",  id_value,                e.idv);
         check("ts_value",  ts_value,                e.tsv);
         check("retry_cnt", 32'(retry_count),        32'd0);
         check("busy_done", 32'(busy),               32'd0);
         check("read_done", 32'(read),               32'd0);
         check("rd_cycles", 32'(rd_cycles - rc0),    32'(e.rdc));
         check("stall_hold", 32'(hold_err - he0),    32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset_n = 1'b1;
      check("rst_read",    32'(read),        32'd0);
      check("rst_address", 32'(address),     32'd0);
      check("rst_busy",    32'(busy),        32'd0);
      check("rst_done",    32'(done),        32'd0);
      check("rst_pass",    32'(pass),        32'd0);
      check("rst_oks",     32'({id_ok, ts_ok, timeout}), 32'd0);
      check("rst_id",      id_value,         32'd0);
      check("rst_ts",      ts_value,         32'd0);
      check("rst_retry",   32'(retry_count), 32'd0);
      idle(2);

      run(0, 1, EXP_ID, EXP_TS, 1'b0);            // nominal
      idle(25);
      run(3, 1, EXP_ID, EXP_TS, 1'b0);            // stalled reads
      idle(25);
      run(0, 1, EXP_ID, 32'h0, 1'b0);             // timestamp mismatch
      idle(25);
      run(0, 1, 32'hDEADBEEF, EXP_TS, 1'b0);      // ID mismatch
      idle(25);
      run(0, 3, EXP_ID, EXP_TS, 1'b0);            // longer latency
      idle(25);
      run(0, 15, EXP_ID, EXP_TS, 1'b0);           // timeout, response arrives late
      idle(25);
      check("late_done",    32'(done),    32'd1);
      check("late_timeout", 32'(timeout), 32'(last_e.tmo));
      check("late_id_ok",   32'(id_ok),   32'(last_e.id_ok));
      check("late_pass",    32'(pass),    32'd0);
      run(0, TO - 1, EXP_ID, EXP_TS, 1'b0);       // data coincident with expiry
      idle(25);
      run(0, TO, EXP_ID, EXP_TS, 1'b0);           // one cycle past expiry
      idle(25);
      run(100, 1, EXP_ID, EXP_TS, 1'b0);          // stuck waitrequest
      idle(25);
      run(0, 1, EXP_ID, EXP_TS, 1'b1);            // start pulsed while busy
      idle(25);

      // Reset during WAIT_TS; the in-flight timestamp response must be ignored.
      cfg_stall = 0;
      cfg_lat   = 3;
      cfg_d0    = EXP_ID;
      cfg_d1    = EXP_TS;
      start     = 1'b1;
      for (int n = 1; n <= 6; n++) begin
         @(posedge clock);
         #1;
         if (n == 1) start = 1'b0;
      end
      check("mid_busy", 32'(busy), 32'd1);
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      check("mr_outs",  32'({read, address, busy, done, pass, id_ok, ts_ok, timeout}), 32'd0);
      check("mr_id",    id_value, 32'd0);
      check("mr_ts",    ts_value, 32'd0);
      idle(5);
      check("mr_late_outs", 32'({busy, done, ts_ok, timeout}), 32'd0);
      check("mr_late_ts",   ts_value, 32'd0);
      idle(20);
      run(0, 1, EXP_ID, EXP_TS, 1'b0);            // recovery after reset

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
